// File: rtl/snax_hwpe_periph_regfile_if.sv
// HWPE peripheral control bus: request/grant transfer plus a registered read response.
// A transfer happens in the cycle where req and gnt are both high, and there is no other acceptance point. The
// requester holds add/wen/be/data/id stable while req is high and gnt is low. The responder
// returns r_valid for exactly one cycle after each granted read, with no backpressure.
interface snax_hwpe_periph_regfile_if #(
  parameter int IdWidth = 5
) ();
  logic               req;
  logic               gnt;
  logic [31:0]        add;
  logic               wen;
  logic [3:0]         be;
  logic [31:0]        data;
  logic [IdWidth-1:0] id;
  logic [31:0]        r_data;
  logic               r_valid;
  logic [IdWidth-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/snax_hwpe_periph_regfile.sv
// Responder end of the HWPE peripheral bus: control/status block, job register file
// and the start/busy/done sequencing toward the accelerator datapath.
module snax_hwpe_periph_regfile #(
  parameter int NumRegs = 16,
  parameter int IdWidth = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  snax_hwpe_periph_regfile_if.slave periph,
  output logic [NumRegs*32-1:0]   regs_o,
  output logic                    start_o,
  input  logic                    done_i,
  output logic                    busy_o,
  output logic                    evt_o
);

  typedef enum logic { BUS_IDLE, BUS_RESP } bus_state_e;
  typedef enum logic { JOB_IDLE, JOB_RUN  } job_state_e;

  bus_state_e         bus_state_q, bus_state_d;
  job_state_e         job_state_q, job_state_d;
  logic               r_valid_q, r_valid_d;
  logic [31:0]        r_data_q, r_data_d;
  logic [IdWidth-1:0] r_id_q, r_id_d;
  logic               start_q, start_d;
  logic               evt_q, evt_d;
  logic               done_q, done_d;
  logic [31:0]        regs_q [NumRegs];
  logic [31:0]        regs_d [NumRegs];

  logic [29:0] word;
  logic        gnt, wr_en, rd_en;
  logic        hit_trig, hit_status, hit_clear;
  logic [31:0] rdata;

  assign word       = periph.add[31:2];
  assign hit_trig   = (word == 30'd0);
  assign hit_status = (word == 30'd1);
  assign hit_clear  = (word == 30'd2);

  assign gnt   = periph.req && (bus_state_q == BUS_IDLE);
  assign wr_en = gnt && !periph.wen;
  assign rd_en = gnt && periph.wen;

  assign busy_o         = (job_state_q == JOB_RUN);
  assign start_o        = start_q;
  assign evt_o          = evt_q;
  assign periph.gnt     = gnt;
  assign periph.r_valid = r_valid_q;
  assign periph.r_data  = r_data_q;
  assign periph.r_id    = r_id_q;

  // Read mux; STATUS reflects the registered state, so a same-cycle done_i is not yet visible.
  always_comb begin
    rdata = '0;
    if (hit_status) rdata = {30'd0, done_q, busy_o};
    for (int i = 0; i < NumRegs; i++) begin
      if (word == 30'(16 + i)) rdata = regs_q[i];
    end
  end

  always_comb begin
    bus_state_d = BUS_IDLE;
    r_valid_d   = 1'b0;
    r_data_d    = '0;
    r_id_d      = '0;
    if (rd_en) begin
      bus_state_d = BUS_RESP;
      r_valid_d   = 1'b1;
      r_data_d    = rdata;
      r_id_d      = periph.id;
    end
  end

  // Completion wins over a coincident TRIGGER (ignored in JOB_RUN) and over a coincident CLEAR.
  always_comb begin
    job_state_d = job_state_q;
    start_d     = 1'b0;
    evt_d       = 1'b0;
    done_d      = done_q;
    if (wr_en && hit_clear) done_d = 1'b0;
    case (job_state_q)
      JOB_IDLE: begin
        if (wr_en && hit_trig) begin
          job_state_d = JOB_RUN;
          start_d     = 1'b1;
          done_d      = 1'b0;
        end
      end
      JOB_RUN: begin
        if (done_i) begin
          job_state_d = JOB_IDLE;
          evt_d       = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: job_state_d = JOB_IDLE;
    endcase
  end

  // Job registers are frozen while a job is in flight.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && !busy_o && (word == 30'(16 + i))) begin
        for (int k = 0; k < 4; k++) begin
          if (periph.be[k]) regs_d[i][8*k +: 8] = periph.data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumRegs; i++) regs_o[32*i +: 32] = regs_q[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_state_q <= BUS_IDLE;
      job_state_q <= JOB_IDLE;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_id_q      <= '0;
      start_q     <= 1'b0;
      evt_q       <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      job_state_q <= job_state_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      r_id_q      <= r_id_d;
      start_q     <= start_d;
      evt_q       <= evt_d;
      done_q      <= done_d;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// Self-checking bench for snax_hwpe_periph_regfile: read responses go through an expected queue.
module tb_snax_hwpe_periph_regfile;
  localparam int NumRegs = 16;
  localparam int IdWidth = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NumRegs*32-1:0] regs;
  logic                  start, done, busy, evt;

  int checks = 0;
  int errors = 0;

  logic [31:0]        exp_q[$];
  logic [IdWidth-1:0] exp_id_q[$];
  logic [31:0]        mdl [NumRegs];

  snax_hwpe_periph_regfile_if #(.IdWidth(IdWidth)) periph_if ();

  snax_hwpe_periph_regfile #(.NumRegs(NumRegs), .IdWidth(IdWidth)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .periph  (periph_if.slave),
    .regs_o  (regs),
    .start_o (start),
    .done_i  (done),
    .busy_o  (busy),
    .evt_o   (evt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    periph_if.req  = 1'b0;
    periph_if.add  = '0;
    periph_if.wen  = 1'b0;
    periph_if.be   = '0;
    periph_if.data = '0;
    periph_if.id   = '0;
  endtask

  // Pops the scoreboard and compares it to the response visible this cycle.
  task automatic check_resp(input string name);
    logic [31:0]        ed;
    logic [IdWidth-1:0] ei;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: response with empty expected queue", name);
      return;
    end
    ed = exp_q.pop_front();
    ei = exp_id_q.pop_front();
    if (periph_if.r_valid !== 1'b1 || periph_if.r_data !== ed || periph_if.r_id !== ei) begin
      errors++;
      $display("FAIL %s: r_valid=%0b r_data=%h r_id=%0d, required 1 %h %0d",
               name, periph_if.r_valid, periph_if.r_data, periph_if.r_id, ed, ei);
    end
  endtask

  // Driver: called at posedge+1, returns at posedge+1 of the cycle after the grant.
  task automatic bus_xfer(input logic [31:0] a, input logic rd, input logic [3:0] be,
                          input logic [31:0] d, input logic [IdWidth-1:0] id,
                          input logic [31:0] exp_d, input string name);
    int n = 0;
    periph_if.req  = 1'b1;
    periph_if.add  = a;
    periph_if.wen  = rd;
    periph_if.be   = be;
    periph_if.data = d;
    periph_if.id   = id;
    #1;
    while (periph_if.gnt !== 1'b1 && n < 8) begin
      @(posedge clk); #1; n++;
    end
    if (periph_if.gnt !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_gnt_timeout: gnt=%b, required 1", name, periph_if.gnt);
    end else if (rd) begin
      exp_q.push_back(exp_d);
      exp_id_q.push_back(id);
    end
    @(posedge clk); #1;
    idle_bus();
    if (rd) check_resp(name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_xfer(a, 1'b0, be, d, '0, '0, "write");
  endtask

  task automatic rd(input logic [31:0] a, input logic [IdWidth-1:0] id,
                    input logic [31:0] exp_d, input string name);
    bus_xfer(a, 1'b1, 4'h0, '0, id, exp_d, name);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    done  = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({start, busy, evt, periph_if.r_valid, periph_if.gnt} !== 5'b0 ||
        periph_if.r_data !== 32'h0 || periph_if.r_id !== '0 || regs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b busy=%b evt=%b rv=%b gnt=%b rdata=%h rid=%0d regs_nz=%b, required all 0",
               start, busy, evt, periph_if.r_valid, periph_if.gnt, periph_if.r_data,
               periph_if.r_id, |regs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h04, 5'd7, 32'h0, "reset_status");
  endtask

  task automatic test_write_read();
    wr(32'h44, 32'hDEADBEEF, 4'hF);
    rd(32'h44, 5'd3, 32'hDEADBEEF, "rw_0x44");
    wr(32'h44, 32'h000000AA, 4'h1);
    rd(32'h44, 5'd4, 32'hDEADBEAA, "be_lane0");
    wr(32'h44, 32'h11223344, 4'h0);
    rd(32'h47, 5'd5, 32'hDEADBEAA, "be_zero_unaligned");
    wr(32'h80, 32'hFFFFFFFF, 4'hF);
    rd(32'h80, 5'd6, 32'h0, "unmapped_0x80");
    rd(32'h00, 5'd8, 32'h0, "trigger_reads_0");
    rd(32'h08, 5'd9, 32'h0, "clear_reads_0");
  endtask

  task automatic test_random_regs();
    logic [31:0] d;
    logic [3:0]  be;
    for (int i = 0; i < NumRegs; i++) begin
      d = $urandom();
      wr(32'h40 + 32'(4*i), d, 4'hF);
      mdl[i] = d;
    end
    for (int i = 0; i < NumRegs; i++) begin
      d  = $urandom();
      be = 4'($urandom_range(0, 15));
      wr(32'h40 + 32'(4*i), d, be);
      for (int k = 0; k < 4; k++) if (be[k]) mdl[i][8*k +: 8] = d[8*k +: 8];
    end
    for (int i = 0; i < NumRegs; i++) begin
      rd(32'h40 + 32'(4*i), 5'($urandom_range(0, 31)), mdl[i], "rand_reg");
      checks++;
      if (regs[32*i +: 32] !== mdl[i]) begin
        errors++;
        $display("FAIL regs_o[%0d]: got %h, required %h", i, regs[32*i +: 32], mdl[i]);
      end
    end
  endtask

  task automatic test_job();
    wr(32'h44, 32'hDEADBEEF, 4'hF);
    check_bit("idle_done_ignored_pre", evt, 1'b0);
    pulse_done();
    check_bit("idle_done_ignored_evt", evt, 1'b0);
    check_bit("idle_done_ignored_busy", busy, 1'b0);
    wr(32'h00, 32'h0, 4'h0);
    check_bit("start_pulse", start, 1'b1);
    check_bit("busy_after_trigger", busy, 1'b1);
    @(posedge clk); #1;
    check_bit("start_one_cycle", start, 1'b0);
    rd(32'h04, 5'd1, 32'h1, "status_busy");
    wr(32'h44, 32'h12345678, 4'hF);
    rd(32'h44, 5'd2, 32'hDEADBEEF, "locked_write");
    wr(32'h00, 32'h0, 4'hF);
    check_bit("trigger_in_run_ignored", start, 1'b0);
    pulse_done();
    check_bit("evt_pulse", evt, 1'b1);
    check_bit("busy_clear", busy, 1'b0);
    @(posedge clk); #1;
    check_bit("evt_one_cycle", evt, 1'b0);
    rd(32'h04, 5'd3, 32'h2, "status_done");
    wr(32'h08, 32'h0, 4'hF);
    rd(32'h04, 5'd4, 32'h0, "status_cleared");
  endtask

  task automatic test_back_to_back();
    // Read into RESP, then a second read must stall one cycle.
    rd(32'h30, 5'd9, 32'h0, "unmapped_0x30");
    periph_if.req = 1'b1; periph_if.add = 32'h44; periph_if.wen = 1'b1; periph_if.id = 5'd10;
    #1;
    check_bit("stall_in_resp", periph_if.gnt, 1'b0);
    @(posedge clk); #1;
    check_bit("gnt_after_resp", periph_if.gnt, 1'b1);
    exp_q.push_back(32'hDEADBEEF); exp_id_q.push_back(5'd10);
    @(posedge clk); #1;
    idle_bus();
    check_resp("stalled_read");
    @(posedge clk); #1;
    check_bit("rvalid_low_after_resp", periph_if.r_valid, 1'b0);
    // Writes stream at one per cycle.
    periph_if.req = 1'b1; periph_if.wen = 1'b0; periph_if.be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      periph_if.add  = 32'h48 + 32'(4*i);
      periph_if.data = 32'hA0 + 32'(i);
      #1;
      check_bit("b2b_write_gnt", periph_if.gnt, 1'b1);
      @(posedge clk); #1;
    end
    idle_bus();
    rd(32'h54, 5'd11, 32'hA3, "b2b_last");
  endtask

  task automatic test_simultaneous();
    // TRIGGER with done_i while running: done handled, trigger dropped.
    wr(32'h00, 32'h0, 4'hF);
    periph_if.req = 1'b1; periph_if.add = 32'h00; periph_if.wen = 1'b0; periph_if.be = 4'hF;
    done = 1'b1;
    @(posedge clk); #1;
    idle_bus(); done = 1'b0;
    check_bit("trig_done_no_start", start, 1'b0);
    check_bit("trig_done_busy", busy, 1'b0);
    check_bit("trig_done_evt", evt, 1'b1);
    rd(32'h04, 5'd12, 32'h2, "trig_done_status");
    // STATUS read with done_i returns pre-update value.
    wr(32'h00, 32'h0, 4'hF);
    periph_if.req = 1'b1; periph_if.add = 32'h04; periph_if.wen = 1'b1; periph_if.id = 5'd13;
    done = 1'b1;
    exp_q.push_back(32'h1); exp_id_q.push_back(5'd13);
    @(posedge clk); #1;
    idle_bus(); done = 1'b0;
    check_resp("status_with_done");
    // CLEAR with done_i: sticky ends set.
    wr(32'h00, 32'h0, 4'hF);
    periph_if.req = 1'b1; periph_if.add = 32'h08; periph_if.wen = 1'b0; periph_if.be = 4'hF;
    done = 1'b1;
    @(posedge clk); #1;
    idle_bus(); done = 1'b0;
    rd(32'h04, 5'd14, 32'h2, "clear_with_done");
  endtask

  task automatic test_reset_mid();
    wr(32'h00, 32'h0, 4'hF);
    periph_if.req = 1'b1; periph_if.add = 32'h44; periph_if.wen = 1'b1; periph_if.id = 5'd15;
    @(posedge clk); #1;
    idle_bus();
    rst_n = 1'b0;
    #1;
    checks++;
    if (periph_if.r_valid !== 1'b0 || busy !== 1'b0 || regs !== '0 || periph_if.r_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: r_valid=%b busy=%b regs_nz=%b r_data=%h, required 0 0 0 0",
               periph_if.r_valid, busy, |regs, periph_if.r_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h04, 5'd16, 32'h0, "status_after_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_random_regs();
    test_job();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
